// File: rtl/uart_tx.sv
// Serial transmitter: DBIT data bits, LSB first, one start bit and an SB_TICK-tick stop bit.
// One bit period is 16 baud ticks, and one baud tick is BAUD_DIV clocks.
module uart_tx #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 163
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DBIT-1:0] i_tx_data,
    input  logic            is_tx_start,
    output logic            o_tx,
    output logic            os_tx_done,
    output logic            o_tx_busy,
    output logic [1:0]      o_dbg_state
);

    localparam int BCW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int NBW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
    localparam logic [NBW-1:0] BIT_LAST  = NBW'(DBIT - 1);
    localparam logic [3:0]     STOP_LAST = 4'(SB_TICK - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [BCW-1:0]  baud_q, baud_d;
    logic [3:0]      tick_q, tick_d;
    logic [NBW-1:0]  bit_q, bit_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic            tx_q, tx_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            baud_tick;
    logic            accept;

    assign baud_tick = (baud_q == BAUD_LAST);
    assign accept    = (state_q == IDLE) && is_tx_start;

    // Restarting the baud counter on acceptance makes the start bit exactly 16 ticks long.
    always_comb begin
        baud_d = baud_q + BCW'(1);
        if (accept || baud_tick) begin
            baud_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (is_tx_start) begin
                    sh_d    = i_tx_data;
                    tick_d  = '0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_q == 4'd15) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        tx_d    = sh_q[0];
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_q == 4'd15) begin
                        tick_d = '0;
                        if (bit_q == BIT_LAST) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            sh_d  = sh_q >> 1;
                            bit_d = bit_q + NBW'(1);
                            tx_d  = sh_d[0];
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick_q == STOP_LAST) begin
                        tick_d  = '0;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset drops any frame in flight; done stays low so the aborted frame is never reported.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign o_tx        = tx_q;
    assign os_tx_done  = done_q;
    assign o_tx_busy   = busy_q;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: each start pushes the expected line levels of the frame,
// which are popped and compared at the middle of every bit period.
module tb_uart_tx;

    localparam int DBIT       = 8;
    localparam int SB_TICK    = 16;
    localparam int BAUD_DIV   = 2;
    localparam int BIT_CLKS   = 16 * BAUD_DIV;
    localparam int FRAME_CLKS = BIT_CLKS * (DBIT + 1) + SB_TICK * BAUD_DIV;

    logic            clk;
    logic            rst;
    logic [DBIT-1:0] i_tx_data;
    logic            is_tx_start;
    logic            o_tx;
    logic            os_tx_done;
    logic            o_tx_busy;
    logic [1:0]      o_dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [0:0] exp_q[$];

    uart_tx #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .BAUD_DIV(BAUD_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tx_data  (i_tx_data),
        .is_tx_start(is_tx_start),
        .o_tx       (o_tx),
        .os_tx_done (os_tx_done),
        .o_tx_busy  (o_tx_busy),
        .o_dbg_state(o_dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after acceptance.
    task automatic start_frame(input logic [7:0] d);
        i_tx_data   = d;
        is_tx_start = 1'b1;
        exp_q.push_back(1'b0);
        for (int i = 0; i < DBIT; i++) exp_q.push_back(d[i]);
        exp_q.push_back(1'b1);
        @(negedge clk);
        is_tx_start = 1'b0;
        i_tx_data   = 8'($urandom_range(0, 255));
    endtask

    // Walks one frame cycle by cycle; ends at the negedge of the done cycle,
    // or right after asserting reset when abort_c is reached.
    task automatic run_frame(input string name, input int inj_c, input logic [7:0] inj_d,
                             input int abort_c);
        int dones = 0;
        logic [0:0] e;
        check({name, "_fall"}, {30'd0, o_tx, o_tx_busy}, 32'b01);
        for (int c = 0; c < FRAME_CLKS; c++) begin
            if (c == abort_c) begin
                rst = 1'b0;
                #1;
                check({name, "_abort"}, {29'd0, o_tx, o_tx_busy, os_tx_done}, 32'b100);
                check({name, "_abort_done"}, dones, 0);
                exp_q.delete();
                return;
            end
            if (c % BIT_CLKS == BIT_CLKS / 2) begin
                check({name, "_q_nonempty"}, {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check({name, "_bit"}, {31'd0, o_tx}, {31'd0, e});
                    check({name, "_busy"}, {31'd0, o_tx_busy}, 1);
                end
            end
            if (os_tx_done) dones++;
            if (c == inj_c) begin
                i_tx_data   = inj_d;
                is_tx_start = 1'b1;
            end
            if (c == inj_c + 1) is_tx_start = 1'b0;
            @(negedge clk);
        end
        check({name, "_no_early_done"}, dones, 0);
        check({name, "_done"}, {29'd0, os_tx_done, o_tx_busy, o_tx}, 32'b101);
        check({name, "_idle_state"}, {30'd0, o_dbg_state}, 0);
        check({name, "_q_drained"}, exp_q.size(), 0);
    endtask

    task automatic check_done_drop(input string name);
        @(negedge clk);
        check({name, "_done_drop"}, {29'd0, os_tx_done, o_tx_busy, o_tx}, 32'b001);
    endtask

    task automatic check_quiet(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({name, "_quiet"}, {29'd0, o_tx, o_tx_busy, os_tx_done}, 32'b100);
        end
    endtask

    initial begin
        // Reset held with a start request present: nothing may leave the block.
        rst         = 1'b0;
        is_tx_start = 1'b1;
        i_tx_data   = 8'hFF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("rst_hold", {29'd0, o_tx, os_tx_done, o_tx_busy}, 32'b100);
        end
        check("rst_state", {30'd0, o_dbg_state}, 0);
        is_tx_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check_quiet("post_rst", 20);

        start_frame(8'hA5);
        run_frame("a5", -1, 8'h00, -1);
        check_done_drop("a5");
        check_quiet("gap1", 5);

        // Second request mid-frame must be dropped without touching the latched byte.
        start_frame(8'h3C);
        run_frame("ign", 100, 8'hFF, -1);
        check_done_drop("ign");
        check_quiet("ign_after", 40);

        // Next frame requested in the done cycle starts with no idle gap.
        start_frame(8'hFF);
        run_frame("ff", -1, 8'h00, -1);
        start_frame(8'h00);
        run_frame("b2b00", -1, 8'h00, -1);
        check_done_drop("b2b00");
        check_quiet("gap2", 5);

        // Reset during data bit 3.
        start_frame(8'h5A);
        run_frame("midrst", -1, 8'h00, 4 * BIT_CLKS + 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_hold", {29'd0, o_tx, o_tx_busy, os_tx_done}, 32'b100);
        end
        rst = 1'b1;
        check_quiet("midrst_rel", 40);
        start_frame(8'hC3);
        run_frame("clean", -1, 8'h00, -1);
        check_done_drop("clean");

        start_frame(8'($urandom_range(0, 255)));
        run_frame("rand", -1, 8'h00, -1);
        check_done_drop("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame.
REQ-002 SHALL have parameter SB_TICK, default 16, stop-bit length in baud ticks (16 = 1 stop bit).
REQ-003 SHALL have parameter BAUD_DIV, default 163, clocks per baud tick; 16 ticks form one bit period.
REQ-004 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_tx_data  input  DBIT  byte to transmit; sampled only when a start is accepted.
REQ-007 SHALL have port is_tx_start  input  1  one-cycle transmit request from the debug FSM.
REQ-008 SHALL have port o_tx  output  1  serial line, idle high, 8N1 format, LSB first.
REQ-009 SHALL have port os_tx_done  output  1  one-cycle pulse when a frame has fully completed.
REQ-010 SHALL have port o_tx_busy  output  1  high while a frame is in progress.

Function
REQ-011 SHALL implement states IDLE, START, DATA, STOP in a registered state machine.
REQ-012 SHALL contain a baud counter 0..BAUD_DIV-1 producing a one-clock tick when it equals BAUD_DIV-1, then wrapping to 0.
REQ-013 SHALL clear the baud counter and the 4-bit tick counter when a start is accepted, so every bit period is exactly 16*BAUD_DIV clocks.
REQ-014 SHALL accept a start only when state is IDLE and is_tx_start=1: latch i_tx_data into a shift register, move to START.
REQ-015 SHALL ignore is_tx_start in START, DATA or STOP; latched data unaffected.
REQ-016 SHALL drive o_tx from a register: 0 during START, shift-register LSB during DATA, 1 in STOP and IDLE.
REQ-017 SHALL leave START after 16 ticks, entering DATA with bit counter 0.
REQ-018 SHALL, in DATA, shift right and increment the bit counter every 16 ticks; after bit DBIT-1 move to STOP.
REQ-019 SHALL leave STOP after SB_TICK ticks, return to IDLE, and assert os_tx_done for exactly the first IDLE cycle.
REQ-020 SHALL accept is_tx_start in the same cycle os_tx_done is high (back-to-back frames, no idle gap beyond that cycle).
REQ-021 SHALL make o_tx fall in the clock after acceptance; start bit, each data bit: 16*BAUD_DIV clocks; stop bit: SB_TICK*BAUD_DIV clocks.
REQ-022 SHALL assert o_tx_busy from the cycle after acceptance through the last STOP cycle; low in IDLE.
REQ-023 SHALL keep the baud counter free-running in IDLE; its value there has no observable effect.

Reset
REQ-024 SHALL on rst=0, regardless of clock or state, force state IDLE, o_tx=1, os_tx_done=0, o_tx_busy=0, all counters and shift register 0.
REQ-025 SHALL abort a frame in progress on reset, with no os_tx_done pulse for the aborted frame.
REQ-026 SHALL after reset release require a new is_tx_start before any transmission.

Verification (BAUD_DIV=2, SB_TICK=16: bit = 32 clocks, frame = 320 clocks)
REQ-027 SHALL cover reset: rst=0 with is_tx_start=1 -> o_tx=1, os_tx_done=0, o_tx_busy=0 throughout.
REQ-028 SHALL cover single frame: i_tx_data=0xA5, one-cycle start -> o_tx 0,1,0,1,0,0,1,0,1,1 at 32-clock spacing; os_tx_done 1 cycle, 320 clocks after o_tx falls.
REQ-029 SHALL cover ignored start: second start with 0xFF at clock 100 of a 0x3C frame -> 0x3C bits unchanged, only one os_tx_done.
REQ-030 SHALL cover back-to-back: start 0x00 asserted in the os_tx_done cycle of a 0xFF frame -> o_tx falls next clock, no extra idle.
REQ-031 SHALL cover mid-frame reset: rst=0 during DATA bit 3 -> o_tx=1 immediately, busy=0, no done pulse; next start sends a clean frame.
REQ-032 SHALL cover extreme data: 0x00 and 0xFF frames -> 8 data bit periods of constant level, correct start and stop bits.
